// File: rtl/ntru_pkg.sv
// Shared definitions for the trit-lifting stream: frame size, coefficient width, trit encoding.
// No logic, no latency.
// Not applicable (types and constants only).
package ntru_pkg;

  localparam int N_DEF      = 701;
  localparam int Q_BITS_DEF = 13;

  typedef enum logic [1:0] {
    ZERO = 2'b00,
    POS  = 2'b01,
    NEG  = 2'b10,
    ILL  = 2'b11
  } trit_t;

  typedef logic [Q_BITS_DEF-1:0] coef_t;

endpackage

// File: rtl/trit_to_zq.sv
// Maps one ternary coefficient to its mod-2^Q_BITS representative and flags the illegal code.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the result with its own transfer strobe.
module trit_to_zq
  import ntru_pkg::*;
#(
  parameter int Q_BITS = Q_BITS_DEF
) (
  input  logic [1:0]        trit,
  output logic [Q_BITS-1:0] coef,
  output logic              illegal
);

  // -1 is represented as all ones; the illegal code lifts to 0 so the stream keeps flowing.
  always_comb begin
    coef    = '0;
    illegal = 1'b0;
    case (trit_t'(trit))
      ZERO:    coef = '0;
      POS:     coef = {{(Q_BITS-1){1'b0}}, 1'b1};
      NEG:     coef = '1;
      ILL:     illegal = 1'b1;
      default: coef = '0;
    endcase
  end

endmodule

// File: rtl/lift_stream.sv
// Lifts a stream of ternary polynomial coefficients to mod-2^Q_BITS; with LIFT_PHI1_EN defined it also multiplies by (x-1) mod (x^N - 1).
// One cycle from input transfer to out_valid; LIFT_PHI1_EN adds one flush beat per frame (N inputs per N+1 cycles).
// Single output register: in_ready drops while the output is held by !out_ready (and during the flush beat).
module lift_stream
  import ntru_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int Q_BITS = Q_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_trit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Q_BITS-1:0]    out_coef,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 err_illegal
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [IDX_W-1:0]  in_cnt;
  logic [Q_BITS-1:0] coef;
  logic              illegal;
  logic              accept;

  trit_to_zq #(.Q_BITS(Q_BITS)) u_map (
    .trit    (in_trit),
    .coef    (coef),
    .illegal (illegal)
  );

  assign accept = in_valid && in_ready;

  // Coefficient index within the frame and the sticky illegal-trit flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_cnt      <= '0;
      err_illegal <= 1'b0;
    end else if (accept) begin
      in_cnt <= (in_cnt == LAST_IDX) ? '0 : in_cnt + 1'b1;
      if (illegal) err_illegal <= 1'b1;
    end
  end

`ifdef LIFT_PHI1_EN
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]        state;
  logic [Q_BITS-1:0] c0;    // first coefficient, needed for the wrap-around term
  logic [Q_BITS-1:0] prev;  // c[i-1] for the running difference

  assign in_ready = rst_n && (state == ST_RUN) && (!out_valid || out_ready);

  // Output register: emits c[i-1]-c[i] per input, then the wrap term c[N-1]-c[0] in FLUSH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      c0        <= '0;
      prev      <= '0;
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (state == ST_FLUSH) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_coef  <= prev - c0;
        out_idx   <= '0;
        out_last  <= 1'b1;
        state     <= ST_RUN;
      end
    end else if (accept) begin
      prev <= coef;
      if (in_cnt == '0) begin
        // Index 0 only primes the difference chain; no beat is produced.
        c0        <= coef;
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b1;
        out_coef  <= prev - coef;
        out_idx   <= in_cnt;
        out_last  <= 1'b0;
        if (in_cnt == LAST_IDX) state <= ST_FLUSH;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = rst_n && (!out_valid || out_ready);

  // Output register: registered trit mapping, reloaded in the same cycle it drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_coef  <= coef;
      out_idx   <= in_cnt;
      out_last  <= (in_cnt == LAST_IDX);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_lift_stream.sv
// Bench for lift_stream: frame-level model of the lifted (optionally (x-1)-multiplied) stream,
// checked every cycle by a monitor, plus hand-computed literal expectations.
module tb_lift_stream;

`ifdef LIFT_PHI1_EN
  localparam int N = 4;
`else
  localparam int N = 701;
`endif
  localparam int QB = 13;
  localparam int QM = 1 << QB;

  typedef struct {
    int idx;
    int coef;
    int last;
  } beat_t;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_trit;
  logic                 out_valid;
  logic                 out_ready;
  logic [QB-1:0]        out_coef;
  logic [$clog2(N)-1:0] out_idx;
  logic                 out_last;
  logic                 err_illegal;

  lift_stream #(.N(N), .Q_BITS(QB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_trit     (in_trit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_coef    (out_coef),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  beat_t expq[$];
  int    cval[N];
  int    mcnt = 0;
  int    err_m = 0;
  int    g = 0;
  int    limit = 1 << 30;
  bit    stream_en = 0;
  int    cyc = 0;
  int    seen_idx[$];
  int    seen_coef[$];
  int    seen_last[$];
  int    last_cnt = 0, last_cyc = -1, last_idx = -1;
  int    next_cyc = -1, next_idx = -1;
  bit    after_last = 0;

  function automatic int val(input logic [1:0] t);
    case (t)
      2'b01:   return 1;
      2'b10:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int modq(input int x);
    return ((x % QM) + QM) % QM;
  endfunction

  function automatic logic [1:0] gen(input int k);
`ifdef LIFT_PHI1_EN
    logic [1:0] tbl [4];
    tbl = '{2'b01, 2'b00, 2'b10, 2'b01};
    return tbl[k % 4];
`else
    if (k == 10) return 2'b11;
    return 2'(k % 3);
`endif
  endfunction

  task automatic model_accept(input logic [1:0] t);
    beat_t b;
`ifdef LIFT_PHI1_EN
    cval[mcnt] = val(t);
    if (mcnt >= 1) begin
      b.idx = mcnt; b.coef = modq(cval[mcnt-1] - cval[mcnt]); b.last = 0;
      expq.push_back(b);
    end
    if (mcnt == N - 1) begin
      b.idx = 0; b.coef = modq(cval[N-1] - cval[0]); b.last = 1;
      expq.push_back(b);
    end
`else
    b.idx = mcnt; b.coef = modq(val(t)); b.last = (mcnt == N - 1) ? 1 : 0;
    expq.push_back(b);
`endif
    if (t == 2'b11) err_m = 1;
    mcnt = (mcnt + 1) % N;
  endtask

  // Input driver: presents the next trit of the directed sequence whenever enabled.
  always @(posedge clk) begin
    #1;
    in_valid = stream_en && (g < limit);
    in_trit  = gen(g);
  end

  // Monitor: compares every output transfer, hold stability, latency and flags with the model.
  bit p_acc = 0, p_flush = 0, p_hold = 0;
  int h_coef = 0, h_idx = 0, h_last = 0;
  always @(negedge clk) begin
    bit acc;
    beat_t e;
    cyc++;
    if (!rst_n) begin
      check("in_ready_in_reset", in_ready, 0);
      expq.delete();
      seen_idx.delete(); seen_coef.delete(); seen_last.delete();
      mcnt = 0; err_m = 0; p_acc = 0; p_flush = 0; p_hold = 0;
      last_cnt = 0; after_last = 0;
    end else begin
      if (p_acc)   check("latency_out_valid", out_valid, 1);
      if (p_flush) check("flush_in_ready", in_ready, 0);
      if (p_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_coef", out_coef, h_coef);
        check("hold_idx", out_idx, h_idx);
        check("hold_last", out_last, h_last);
      end
      check("err_illegal", err_illegal, err_m);
      if (out_valid && out_ready) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: idx=%0d coef=%0d with empty model queue", out_idx, out_coef);
        end else begin
          e = expq.pop_front();
          if (out_idx != e.idx || out_coef != e.coef || out_last != e.last) begin
            bad++;
            $display("FAIL beat: got idx=%0d coef=%0d last=%0d, expected idx=%0d coef=%0d last=%0d",
                     out_idx, out_coef, out_last, e.idx, e.coef, e.last);
          end
        end
        seen_idx.push_back(int'(out_idx));
        seen_coef.push_back(int'(out_coef));
        seen_last.push_back(int'(out_last));
        if (after_last) begin
          next_cyc = cyc; next_idx = out_idx; after_last = 0;
        end
        if (out_last) begin
          last_cnt++; last_cyc = cyc; last_idx = out_idx; after_last = 1;
        end
      end
      acc = in_valid && in_ready;
`ifdef LIFT_PHI1_EN
      p_acc   = acc && (mcnt != 0);
      p_flush = acc && (mcnt == N - 1);
`else
      p_acc   = acc;
      p_flush = 0;
`endif
      if (acc) begin
        model_accept(in_trit);
        g++;
      end
      p_hold = out_valid && !out_ready;
      h_coef = out_coef; h_idx = out_idx; h_last = out_last;
    end
  end

  task automatic wait_g(input int target, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (g < target && n < 5000);
    if (g < target) begin
      total++; bad++;
      $display("FAIL timeout_%s: accepted %0d, needed %0d", name, g, target);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_coef"}, out_coef, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_err_illegal"}, err_illegal, 0);
  endtask

  task automatic stall(input int cycles);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #3;
      check("stall_in_ready", in_ready, 0);
    end
    #1 out_ready = 1'b1;
  endtask

  initial begin
    int t;
    rst_n = 1'b0; in_valid = 1'b0; in_trit = 2'b00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 check_zero_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1; stream_en = 1;

`ifdef LIFT_PHI1_EN
    // Frame +1,0,-1,+1 -> idx1=1, idx2=1, idx3=8190, flush idx0=0 last.
    limit = 4;
    wait_g(4, "phi1_frame0");
    repeat (4) @(posedge clk);
    #3;
    check("phi1_beats", seen_idx.size(), 4);
    if (seen_idx.size() >= 4) begin
      check("phi1_idx1", seen_idx[0], 1);  check("phi1_coef1", seen_coef[0], 1);
      check("phi1_idx2", seen_idx[1], 2);  check("phi1_coef2", seen_coef[1], 1);
      check("phi1_idx3", seen_idx[2], 3);  check("phi1_coef3", seen_coef[2], 8190);
      check("phi1_idx0", seen_idx[3], 0);  check("phi1_coef0", seen_coef[3], 0);
      check("phi1_last", seen_last[3], 1); check("phi1_last_early", seen_last[2], 0);
    end
    // Two more frames back to back with a downstream stall inside.
    limit = 12;
    wait_g(6, "phi1_pre_stall");
    stall(3);
    wait_g(12, "phi1_frames");
    repeat (6) @(posedge clk);
    #3;
    check("phi1_frames_last_count", last_cnt, 3);
`else
    // First three trits 0,+1,-1 -> 0,1,8191 at idx 0,1,2; illegal trit at idx 10.
    wait_g(20, "first_beats");
    #3;
    if (seen_idx.size() >= 11) begin
      check("idx0", seen_idx[0], 0); check("coef0", seen_coef[0], 0);
      check("idx1", seen_idx[1], 1); check("coef1", seen_coef[1], 1);
      check("idx2", seen_idx[2], 2); check("coef2", seen_coef[2], 8191);
      check("illegal_idx", seen_idx[10], 10); check("illegal_coef", seen_coef[10], 0);
    end else begin
      check("first_beat_count", seen_idx.size(), 11);
    end
    check("err_illegal_set", err_illegal, 1);
    wait_g(100, "pre_stall");
    stall(5);
    // Frame boundary: single last on idx 700, idx 0 in the very next cycle.
    wait_g(N + 6, "frame_wrap");
    #3;
    check("last_count", last_cnt, 1);
    check("last_idx", last_idx, N - 1);
    check("after_last_idx", next_idx, 0);
    check("after_last_gap", next_cyc - last_cyc, 1);
    // Reset in the middle of the second frame.
    wait_g(N + 350, "mid_frame");
    #3 check("err_illegal_sticky", err_illegal, 1);
    #1 rst_n = 1'b0;
    @(posedge clk); #3 check_zero_outputs("mid_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    t = g + 10;
    wait_g(t, "post_reset");
    #3;
    if (seen_idx.size() > 0) check("post_reset_first_idx", seen_idx[0], 0);
    else check("post_reset_beats", seen_idx.size(), 1);
`endif
    stream_en = 0;
    repeat (5) @(posedge clk);
    #3 check("drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lift_stream.md
LIFT_STREAM -- requirements
Module: lift_stream

Interface
REQ-001 Parameter N, default 701: coefficients per polynomial frame.
REQ-002 Parameter Q_BITS, default 13: width of mod-q output coefficients (q = 2^Q_BITS).
REQ-003 Port clk  input  1: single clock; all logic on rising edge.
REQ-004 Port rst_n  input  1: synchronous, active-low reset.
REQ-005 Port in_valid  input  1: in_trit holds a valid coefficient.
REQ-006 Port in_ready  output  1: block accepts in_trit this cycle.
REQ-007 Port in_trit  input  2: ternary coefficient; 2'b00 = 0, 2'b01 = +1, 2'b10 = -1, 2'b11 illegal.
REQ-008 Port out_valid  output  1: out_coef/out_idx valid.
REQ-009 Port out_ready  input  1: downstream accepts output this cycle.
REQ-010 Port out_coef  output  Q_BITS: lifted coefficient mod 2^Q_BITS (-1 = all ones, e.g. 8191).
REQ-011 Port out_idx  output  $clog2(N): coefficient index of out_coef.
REQ-012 Port out_last  output  1: final output beat of the frame.
REQ-013 Port err_illegal  output  1: sticky flag, illegal trit accepted since reset.

Function
REQ-014 Input transfer occurs on in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-015 Trit mapping: 0 -> 0, +1 -> 1, -1 -> 2^Q_BITS-1; illegal 2'b11 maps to 0 and sets err_illegal.
REQ-016 Input counter in_cnt runs 0..N-1 and wraps to 0 after accepting coefficient N-1; frames are back-to-back with no gap.
REQ-017 Output stage is a single register; in_ready = !out_valid || out_ready in state RUN; latency from input transfer to out_valid is exactly 1 cycle.
REQ-018 out_valid and out_coef/out_idx/out_last hold stable while out_valid && !out_ready.
REQ-019 Full throughput: one coefficient per cycle sustained when out_ready is held high.
REQ-020 FSM states RUN and FLUSH; FLUSH exists only when LIFT_PHI1_EN is defined (Configuration).
REQ-021 Without LIFT_PHI1_EN: out_coef = map(in_trit), out_idx = in_cnt, out_last asserted on index N-1.
REQ-022 Arithmetic is modulo 2^Q_BITS; all sums and differences truncate to Q_BITS bits.
REQ-023 Simultaneous out_ready and new input in the same cycle: output register reloads without a bubble.

Reset
REQ-024 On rst_n low at a clock edge: out_valid=0, out_coef=0, out_idx=0, out_last=0, err_illegal=0, in_cnt=0, FSM=RUN, stored coefficients=0.
REQ-025 Reset mid-frame discards the partial frame; the first input after reset is index 0.
REQ-026 in_ready = 0 while rst_n is low.

Configuration
REQ-027 Macro LIFT_PHI1_EN: when defined, output is the product with (x-1) mod (x^N - 1): out[i] = c[i-1] - c[i], with c[-1] = c[N-1].
REQ-028 With LIFT_PHI1_EN: coefficient 0 is stored; for input i>=1 emit out_idx=i, out_coef=c[i-1]-c[i]; after accepting index N-1 FSM enters FLUSH, deasserts in_ready, and emits out_idx=0, out_coef=c[N-1]-c[0], out_last=1, then returns to RUN.
REQ-029 With LIFT_PHI1_EN: accepting index 0 produces no output beat; throughput is N inputs per N+1 cycles.
REQ-030 Without LIFT_PHI1_EN: no stored-coefficient registers, no FLUSH state, output is a pure registered mapping.

Structure
REQ-031 Package ntru_pkg holds N default, Q_BITS default, the trit encoding typedef (enum of ZERO/POS/NEG/ILL), and the Q_BITS coefficient typedef.
REQ-032 Sub-module trit_to_zq (combinational, trit in, Q_BITS coefficient plus illegal flag out) is instantiated once for the mapping.

Verification
REQ-033 No macro, N=701, out_ready=1, stream trits 0,+1,-1 -> out_coef 0,1,8191 with out_idx 0,1,2, one cycle after each input.
REQ-034 No macro, full frame of 701 inputs then second frame -> out_last on idx 700 only, next output idx 0, no bubble.
REQ-035 out_ready low for 5 cycles while in_valid high -> in_ready low after one held beat, held output unchanged, no data lost.
REQ-036 Inject 2'b11 at index 10 -> out_coef 0 at idx 10, err_illegal rises and stays high until rst_n low.
REQ-037 LIFT_PHI1_EN, N=4, inputs +1,0,-1,+1 -> outputs idx1=1, idx2=1, idx3=8190, then FLUSH idx0=0 with out_last, in_ready low during FLUSH.
REQ-038 Assert rst_n low at input index 350 -> all outputs zero next cycle; next accepted input reported as idx 0.
